// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and widths for the flash audio playback path
package audio_pkg;

  localparam int ADDR_W   = 23;
  localparam int DATA_W   = 32;
  localparam int SAMPLE_W = 16;

  localparam logic [ADDR_W-1:0] MAX_WORD_ADDR = 23'h7FFFF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    EMIT_FIRST,
    HOLD,
    EMIT_SECOND,
    ADVANCE
  } reader_state_t;

  typedef enum logic [1:0] {
    M_IDLE,
    M_REQ,
    M_WAIT
  } master_state_t;

endpackage

// File: rtl/avalon_read_master.sv
// rtl/avalon_read_master.sv - single-word Avalon-MM read with start/done handshake
// FLASH_TIMEOUT_EN adds a REQ+WAIT cycle limit that completes the read with zero data.
module avalon_read_master
  import audio_pkg::*;
#(
  parameter int ADDR_W = audio_pkg::ADDR_W,
  parameter int DATA_W = audio_pkg::DATA_W
`ifdef FLASH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              waitrequest_i,
  input  logic              readdatavalid_i,
  input  logic [DATA_W-1:0] readdata_i,
  output logic              read_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              accept_o,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o
`ifdef FLASH_TIMEOUT_EN
  ,
  output logic              timeout_o
`endif
);

  master_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              data_hit;
  logic              timeout_hit;

  // Only M_WAIT listens to readdatavalid, so a stale beat after reset is ignored.
  assign data_hit = (state_q == M_WAIT) && readdatavalid_i;

`ifdef FLASH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || start_i) begin
      cnt_q <= '0;
    end else if (state_q != M_IDLE) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout_hit = (state_q != M_IDLE) && !data_hit &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o   = timeout_hit;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= M_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      M_IDLE:  if (start_i) state_d = M_REQ;
      M_REQ: begin
        if (timeout_hit)   state_d = M_IDLE;
        else if (accept_o) state_d = M_WAIT;
      end
      M_WAIT:  if (data_hit || timeout_hit) state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  assign read_o    = (state_q == M_REQ) && !timeout_hit;
  assign accept_o  = read_o && !waitrequest_i;
  assign done_o    = data_hit || timeout_hit;
  assign address_o = addr_q;
  assign data_o    = data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (start_i) addr_q <= addr_i;
      if (data_hit) begin
        data_q <= readdata_i;
      end else if (timeout_hit) begin
        data_q <= '0;
      end
    end
  end

endmodule

// File: rtl/flash_sample_reader.sv
// rtl/flash_sample_reader.sv - turns flash words into two audio samples per word on sample ticks
// FLASH_TIMEOUT_EN enables the read timeout and the sticky flash_timeout port.
module flash_sample_reader
  import audio_pkg::*;
#(
  parameter int ADDR_W   = audio_pkg::ADDR_W,
  parameter int DATA_W   = audio_pkg::DATA_W,
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W
`ifdef FLASH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play,
  input  logic                direction,
  input  logic                sample_tick,
  input  logic [ADDR_W-1:0]   word_addr,
  output logic                flash_read,
  output logic [ADDR_W-1:0]   flash_address,
  input  logic                flash_waitrequest,
  input  logic                flash_readdatavalid,
  input  logic [DATA_W-1:0]   flash_readdata,
  output logic [SAMPLE_W-1:0] audio_data,
  output logic                audio_valid,
  output logic                addr_advance,
  output logic                overrun
`ifdef FLASH_TIMEOUT_EN
  ,
  output logic                flash_timeout
`endif
);

  reader_state_t       state_q, state_d;
  logic                rd_start, rd_accept, rd_done, rd_timeout;
  logic [DATA_W-1:0]   rd_data;
  logic [SAMPLE_W-1:0] lo_half, hi_half, audio_data_q;
  logic                dir_q, pending_q, overrun_q, cancel_q, audio_valid_q;
  logic                trigger, emit_first, emit_second, tick_busy;

  assign trigger   = play && (sample_tick || pending_q);
  assign lo_half   = rd_data[SAMPLE_W-1:0];
  assign hi_half   = rd_data[DATA_W-1:SAMPLE_W];
  assign tick_busy = (state_q != IDLE) && (state_q != HOLD);

  avalon_read_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
`ifdef FLASH_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
  ) u_master (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (rd_start),
    .addr_i          (word_addr),
    .waitrequest_i   (flash_waitrequest),
    .readdatavalid_i (flash_readdatavalid),
    .readdata_i      (flash_readdata),
    .read_o          (flash_read),
    .address_o       (flash_address),
    .accept_o        (rd_accept),
    .done_o          (rd_done),
    .data_o          (rd_data)
`ifdef FLASH_TIMEOUT_EN
    ,
    .timeout_o       (rd_timeout)
`endif
  );

`ifdef FLASH_TIMEOUT_EN
  logic flash_timeout_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      flash_timeout_q <= 1'b0;
    end else if (rd_timeout) begin
      flash_timeout_q <= 1'b1;
    end
  end
  assign flash_timeout = flash_timeout_q;
`else
  assign rd_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (trigger) state_d = REQ;
      REQ, WAIT_DATA: begin
        // A stopped read still completes on the bus; its data is simply not played.
        if (rd_done) begin
          if (cancel_q || !play) state_d = IDLE;
          else if (rd_timeout)   state_d = EMIT_SECOND;
          else                   state_d = EMIT_FIRST;
        end else if ((state_q == REQ) && rd_accept) begin
          state_d = WAIT_DATA;
        end
      end
      EMIT_FIRST: state_d = HOLD;
      HOLD: begin
        if (!play)                           state_d = IDLE;
        else if (sample_tick || pending_q)   state_d = EMIT_SECOND;
      end
      EMIT_SECOND: state_d = ADVANCE;
      ADVANCE:     state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_start     = 1'b0;
    emit_first   = 1'b0;
    emit_second  = 1'b0;
    addr_advance = 1'b0;
    case (state_q)
      IDLE:        rd_start     = trigger;
      EMIT_FIRST:  emit_first   = 1'b1;
      EMIT_SECOND: emit_second  = 1'b1;
      ADVANCE:     addr_advance = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q         <= 1'b0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      cancel_q      <= 1'b0;
      audio_data_q  <= '0;
      audio_valid_q <= 1'b0;
    end else begin
      audio_valid_q <= emit_first || emit_second;
      if (emit_first)  audio_data_q <= dir_q ? lo_half : hi_half;
      if (emit_second) audio_data_q <= dir_q ? hi_half : lo_half;
      if (rd_start)    dir_q <= direction;

      if (rd_start) begin
        cancel_q <= 1'b0;
      end else if (((state_q == REQ) || (state_q == WAIT_DATA)) && !play) begin
        cancel_q <= 1'b1;
      end

      // One-deep tick queue; IDLE/HOLD consume it, a simultaneous tick re-arms it.
      if (!play) begin
        pending_q <= 1'b0;
      end else if (!tick_busy) begin
        pending_q <= pending_q && sample_tick;
      end else if (sample_tick) begin
        if (pending_q) overrun_q <= 1'b1;
        else           pending_q <= 1'b1;
      end
    end
  end

  assign audio_data  = audio_data_q;
  assign audio_valid = audio_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// tb/tb_flash_sample_reader.sv - directed scoreboard bench for flash_sample_reader
module tb_flash_sample_reader;

  logic        clk = 1'b0;
  logic        reset, play, direction, sample_tick;
  logic [22:0] word_addr;
  logic        flash_read;
  logic [22:0] flash_address;
  logic        flash_waitrequest;
  logic        flash_readdatavalid = 1'b0;
  logic [31:0] flash_readdata = 32'h0;
  logic [15:0] audio_data;
  logic        audio_valid, addr_advance, overrun;

  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;
  int          adv_cnt = 0;
  int          accept_cnt = 0;
  int          rdv_delay = 1;
  logic [31:0] rd_word = 32'h0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  flash_sample_reader dut (
    .clk                 (clk),
    .reset               (reset),
    .play                (play),
    .direction           (direction),
    .sample_tick         (sample_tick),
    .word_addr           (word_addr),
    .flash_read          (flash_read),
    .flash_address       (flash_address),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdatavalid (flash_readdatavalid),
    .flash_readdata      (flash_readdata),
    .audio_data          (audio_data),
    .audio_valid         (audio_valid),
    .addr_advance        (addr_advance),
    .overrun             (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  // Sample monitor: pops the scoreboard on every audio_valid pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (addr_advance) adv_cnt++;
      if (audio_valid) begin
        valid_cnt++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL spurious_sample: observed 0x%0h expected none", audio_data);
        end
        if (exp_q.size() != 0) check("sample", {16'h0, audio_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Flash slave model: readdatavalid arrives rdv_delay cycles after each accept.
  initial begin
    forever begin
      @(negedge clk);
      if (flash_read && !flash_waitrequest && !reset) begin
        accept_cnt++;
        @(posedge clk);
        #1;
        repeat (rdv_delay - 1) begin
          @(posedge clk);
          #1;
        end
        flash_readdatavalid = 1'b1;
        flash_readdata      = rd_word;
        @(posedge clk);
        #1;
        flash_readdatavalid = 1'b0;
      end
    end
  end

  initial begin
    int lat;
    int a0;
    reset = 1'b1; play = 1'b0; direction = 1'b0; sample_tick = 1'b0;
    word_addr = '0; flash_waitrequest = 1'b0;
    step(3);
    check("rst_audio_data", {16'h0, audio_data}, 32'h0);
    check("rst_audio_valid", {31'h0, audio_valid}, 32'h0);
    check("rst_addr_advance", {31'h0, addr_advance}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_flash_read", {31'h0, flash_read}, 32'h0);
    check("rst_flash_address", {9'h0, flash_address}, 32'h0);
    reset = 1'b0;
    step(2);

    // Forward fetch, with a direction flip mid-word that must not affect this word.
    play = 1'b1; direction = 1'b1; word_addr = 23'h00010; rd_word = 32'hBEEF1234;
    exp_q.push_back(16'h1234); exp_q.push_back(16'hBEEF);
    tick();
    lat = 0;
    while (!audio_valid && lat < 20) begin
      step(1);
      lat++;
    end
    check("first_sample_latency", lat, 3);
    check("fwd_address", {9'h0, flash_address}, 32'h10);
    step(4);
    check("fwd_no_early_advance", adv_cnt, 0);
    direction = 1'b0;
    tick();
    step(6);
    check("fwd_advance", adv_cnt, 1);
    check("fwd_valid_count", valid_cnt, 2);

    // Backward fetch of the same word.
    word_addr = 23'h00020;
    exp_q.push_back(16'hBEEF); exp_q.push_back(16'h1234);
    tick();
    step(8);
    tick();
    step(6);
    check("bwd_advance", adv_cnt, 2);
    check("bwd_valid_count", valid_cnt, 4);
    check("bwd_address", {9'h0, flash_address}, 32'h20);

    // Waitrequest stall for 5 cycles.
    direction = 1'b1; word_addr = 23'h00030; rd_word = 32'hCAFE5678;
    flash_waitrequest = 1'b1;
    exp_q.push_back(16'h5678); exp_q.push_back(16'hCAFE);
    a0 = accept_cnt;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_read_held", {31'h0, flash_read}, 32'h1);
      check("stall_addr_held", {9'h0, flash_address}, 32'h30);
      step(1);
    end
    flash_waitrequest = 1'b0;
    step(8);
    check("stall_one_accept", accept_cnt, a0 + 1);
    tick();
    step(6);
    check("stall_advance", adv_cnt, 3);
    check("stall_valid_count", valid_cnt, 6);

    // Two ticks during a slow read: first pends, second overruns.
    word_addr = 23'h00040; rd_word = 32'h11112222; rdv_delay = 20;
    exp_q.push_back(16'h2222); exp_q.push_back(16'h1111);
    tick();
    step(3);
    tick();
    step(3);
    check("overrun_after_pending", {31'h0, overrun}, 32'h0);
    tick();
    check("overrun_set", {31'h0, overrun}, 32'h1);
    step(30);
    check("overrun_valid_count", valid_cnt, 8);
    check("overrun_advance", adv_cnt, 4);
    check("overrun_sticky", {31'h0, overrun}, 32'h1);

    // Stop mid-read: read completes on the bus, nothing is played.
    word_addr = 23'h00050; rdv_delay = 10;
    a0 = accept_cnt;
    tick();
    step(3);
    play = 1'b0;
    step(20);
    check("stop_no_valid", valid_cnt, 8);
    check("stop_no_advance", adv_cnt, 4);
    check("stop_one_accept", accept_cnt, a0 + 1);
    check("stop_read_idle", {31'h0, flash_read}, 32'h0);
    tick();
    step(5);
    check("stop_tick_ignored", accept_cnt, a0 + 1);

    // Restart after stop.
    play = 1'b1; word_addr = 23'h00051; rd_word = 32'hA5A55A5A; rdv_delay = 1;
    exp_q.push_back(16'h5A5A); exp_q.push_back(16'hA5A5);
    tick();
    step(8);
    tick();
    step(6);
    check("restart_valid_count", valid_cnt, 10);
    check("restart_advance", adv_cnt, 5);
    check("restart_audio_hold", {16'h0, audio_data}, 32'hA5A5);

    // Reset mid-read: the late readdatavalid must be ignored.
    rdv_delay = 6;
    check("overrun_before_reset", {31'h0, overrun}, 32'h1);
    tick();
    step(2);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("midrst_audio_data", {16'h0, audio_data}, 32'h0);
    check("midrst_overrun", {31'h0, overrun}, 32'h0);
    check("midrst_flash_read", {31'h0, flash_read}, 32'h0);
    check("midrst_flash_address", {9'h0, flash_address}, 32'h0);
    step(10);
    check("midrst_no_valid", valid_cnt, 10);
    check("midrst_no_advance", adv_cnt, 5);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
